// File: rtl/gf_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gf_scan_ctrl
// Brief    : Round-robin glitch-filter scan controller. One shared sampling
//            prescaler and one evaluation datapath serve CH asynchronous
//            lines; each line keeps a history shift register and drives a
//            debounced level plus registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module gf_scan_ctrl #(
    parameter int CH = 4,
    parameter int N  = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] clk_div,
    input  logic [3:0]    depth,
    input  logic          ovr_clr,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          busy,
    output logic          overrun
);

    localparam int             c_IW   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(CH - 1);
    localparam logic [0:0]     c_IDLE = 1'b0;
    localparam logic [0:0]     c_SCAN = 1'b1;

    // Synchronizer stages; r_sync is the sampled view of each line
    logic [CH-1:0] r_meta;
    logic [CH-1:0] r_sync;

    // Prescaler
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_per;
    logic [DW-1:0] w_per_eff;
    logic [DW-1:0] w_per_cur;
    logic          w_tick;

    // Scheduler state
    logic [0:0]      r_state;
    logic [0:0]      w_state_nx;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_nx;
    logic            r_pend;
    logic            w_pend_nx;
    logic            r_ovr;
    logic            w_ovr_set;
    logic            w_busy;
    logic            w_slot;

    // Evaluation datapath
    logic [N-1:0]  r_hist [CH];
    logic [CH-1:0] r_out;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic [4:0]    w_d;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_new_h;
    logic          w_all1;
    logic          w_all0;

    // Two-flop synchronizer on every raw line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= in;
            r_sync <= r_meta;
        end
    end

    // A new period value is only picked up when the counter sits at zero,
    // so a clk_div change mid-period does not truncate or stretch it.
    assign w_per_eff = (clk_div == '0) ? DW'(1) : clk_div;
    assign w_per_cur = (r_cnt == '0) ? w_per_eff : r_per;
    assign w_tick    = en && (r_cnt == (w_per_cur - DW'(1)));

    // Prescaler counter: runs only while enabled, wraps on the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_per <= '0;
        end else if (!en) begin
            r_cnt <= '0;
        end else begin
            if (r_cnt == '0) begin
                r_per <= w_per_eff;
            end
            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    // Scheduler state register, pending flag and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_pend  <= w_pend_nx;
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Next-state logic: start scans on ticks, queue one tick, drop the rest
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_pend_nx  = r_pend;
        w_ovr_set  = 1'b0;
        if (!en) begin
            w_state_nx = c_IDLE;
            w_idx_nx   = '0;
            w_pend_nx  = 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_tick || r_pend) begin
                        w_state_nx = c_SCAN;
                        w_idx_nx   = '0;
                        // Queued tick and a fresh tick together: keep the fresh one queued
                        w_pend_nx  = r_pend && w_tick;
                    end
                end
                c_SCAN: begin
                    if (w_tick) begin
                        if (r_pend) begin
                            w_ovr_set = 1'b1;
                        end else begin
                            w_pend_nx = 1'b1;
                        end
                    end
                    if (r_idx == c_LAST) begin
                        w_idx_nx = '0;
                        if (r_pend) begin
                            w_state_nx = c_SCAN;
                            w_pend_nx  = 1'b0;
                        end else begin
                            w_state_nx = c_IDLE;
                        end
                    end else begin
                        w_idx_nx = r_idx + c_IW'(1);
                    end
                end
                default: begin
                    w_state_nx = c_IDLE;
                    w_idx_nx   = '0;
                    w_pend_nx  = 1'b0;
                end
            endcase
        end
    end

    // Output decode: a slot is only honoured while enabled
    always_comb begin
        w_busy = (r_state == c_SCAN);
        w_slot = w_busy && en;
    end

    // Depth clamped to [1,N] and turned into a low-bit window mask
    always_comb begin
        if (depth == 4'd0) begin
            w_d = 5'd1;
        end else if ({1'b0, depth} > 5'(N)) begin
            w_d = 5'(N);
        end else begin
            w_d = {1'b0, depth};
        end
        w_mask  = ~({N{1'b1}} << w_d);
        w_new_h = {r_hist[r_idx][N-2:0], r_sync[r_idx]};
        w_all1  = ((w_new_h & w_mask) == w_mask);
        w_all0  = ((w_new_h & w_mask) == '0);
    end

    // Slot update: shift history, settle level, register edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_hist[i] <= '0;
            end
            r_out  <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (w_slot) begin
                r_hist[r_idx] <= w_new_h;
                if (w_all1) begin
                    r_out[r_idx]  <= 1'b1;
                    r_rise[r_idx] <= ~r_out[r_idx];
                end else if (w_all0) begin
                    r_out[r_idx]  <= 1'b0;
                    r_fall[r_idx] <= r_out[r_idx];
                end
            end
        end
    end

    assign out     = r_out;
    assign rise    = r_rise & {CH{en}};
    assign fall    = r_fall & {CH{en}};
    assign busy    = w_busy;
    assign overrun = r_ovr;

endmodule
`default_nettype wire
